register_file: RTL and testbench



---
 rtl/register_file.sv | 63 ++++++
 tb/tb_register_file.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural integer register file: two combinational read ports, one clocked write port, one debug read port.
// Register 0 always reads as zero. Defining REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  assign wr_en = RegWrite && (rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rd] = wd;
    end
    // Entry 0 is pinned to zero so it never holds state.
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = (addr == '0) ? '0 : regs_q[addr];
`ifdef REGFILE_BYPASS_EN
    // Reset suppresses forwarding so outputs are zero while rst_n is low.
    if (rst_n && wr_en && (addr == rd)) begin
      val = wd;
    end
`endif
    return val;
  endfunction

  assign rd1      = read_port(rs1);
  assign rd2      = read_port(rs2);
  assign dbg_data = read_port(dbg_addr);

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow REGFILE_BYPASS_EN when defined.
`timescale 1ns/100ps
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  rs1, rs2, rd, dbg_addr;
  logic [31:0] wd, rd1, rd2, dbg_data;

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RegWrite (RegWrite),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .wd       (wd),
    .rd1      (rd1),
    .rd2      (rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RegWrite = 1'b1;
    rd       = a;
    wd       = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    $display("write x%0d <= %h", a, d);
  endtask

  task automatic test_reset();
    logic [4:0] idx [3];
    idx[0] = 5'd0; idx[1] = 5'd5; idx[2] = 5'd31;
    rst_n = 1'b0; RegWrite = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF;
    rs1 = '0; rs2 = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rs1 = idx[i]; rs2 = idx[i]; dbg_addr = idx[i];
      #1;
      n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL reset_rd1 idx=%0d got=%h exp=0", idx[i], rd1); end
      n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL reset_rd2 idx=%0d got=%h exp=0", idx[i], rd2); end
      n_cmp++; if (dbg_data !== 32'h0) begin n_err++; $display("FAIL reset_dbg idx=%0d got=%h exp=0", idx[i], dbg_data); end
    end
    @(negedge clk);
    RegWrite = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;
    rs1 = 5'd5; rs2 = 5'd31; dbg_addr = 5'd5;
    #1;
    n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL post_reset_rd1 got=%h exp=0", rd1); end
    n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL post_reset_rd2 got=%h exp=0", rd2); end
    n_cmp++; if (dbg_data !== 32'h0) begin n_err++; $display("FAIL post_reset_dbg got=%h exp=0", dbg_data); end
    $display("reset test done");
  endtask

  task automatic test_basic();
    write_reg(5'd7, 32'h12345678);
    write_reg(5'd31, 32'hCAFEF00D);
    rs1 = 5'd7; rs2 = 5'd31; dbg_addr = 5'd7;
    #1;
    n_cmp++; if (rd1 !== 32'h12345678) begin n_err++; $display("FAIL basic_rd1 got=%h exp=12345678", rd1); end
    n_cmp++; if (rd2 !== 32'hCAFEF00D) begin n_err++; $display("FAIL basic_rd2 got=%h exp=cafef00d", rd2); end
    n_cmp++; if (dbg_data !== 32'h12345678) begin n_err++; $display("FAIL basic_dbg got=%h exp=12345678", dbg_data); end
    rs1 = 5'd31; rs2 = 5'd7; dbg_addr = 5'd31;
    #1;
    n_cmp++; if (rd1 !== 32'hCAFEF00D) begin n_err++; $display("FAIL basic_swap_rd1 got=%h exp=cafef00d", rd1); end
    n_cmp++; if (rd2 !== 32'h12345678) begin n_err++; $display("FAIL basic_swap_rd2 got=%h exp=12345678", rd2); end
    n_cmp++; if (dbg_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL basic_swap_dbg got=%h exp=cafef00d", dbg_data); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    RegWrite = 1'b1; rd = 5'd0; wd = 32'hFFFFFFFF;
    rs1 = 5'd0; rs2 = 5'd0; dbg_addr = 5'd0;
    #1;
    n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL x0_bypass_rd1 got=%h exp=0", rd1); end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL x0_rd1 got=%h exp=0", rd1); end
    n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL x0_rd2 got=%h exp=0", rd2); end
    n_cmp++; if (dbg_data !== 32'h0) begin n_err++; $display("FAIL x0_dbg got=%h exp=0", dbg_data); end
    $display("write x0 discarded");
  endtask

  task automatic test_write_enable();
    write_reg(5'd3, 32'h00000011);
    @(negedge clk);
    RegWrite = 1'b0; rd = 5'd3; wd = 32'hA5A5A5A5;
    rs1 = 5'd3; rs2 = 5'd3; dbg_addr = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rd1 !== 32'h00000011) begin n_err++; $display("FAIL we_gate_rd1 got=%h exp=00000011", rd1); end
    n_cmp++; if (dbg_data !== 32'h00000011) begin n_err++; $display("FAIL we_gate_dbg got=%h exp=00000011", dbg_data); end
    $display("gated write x3 ignored");
  endtask

  task automatic test_read_during_write();
    logic [31:0] pre;
    pre = BYP ? 32'h2 : 32'h1;
    write_reg(5'd9, 32'h1);
    @(negedge clk);
    rs1 = 5'd9; rs2 = 5'd9; dbg_addr = 5'd9; rd = 5'd9; wd = 32'h2; RegWrite = 1'b1;
    #1;
    n_cmp++; if (rd1 !== pre) begin n_err++; $display("FAIL rdw_pre_rd1 got=%h exp=%h", rd1, pre); end
    n_cmp++; if (rd2 !== pre) begin n_err++; $display("FAIL rdw_pre_rd2 got=%h exp=%h", rd2, pre); end
    n_cmp++; if (dbg_data !== pre) begin n_err++; $display("FAIL rdw_pre_dbg got=%h exp=%h", dbg_data, pre); end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    n_cmp++; if (rd1 !== 32'h2) begin n_err++; $display("FAIL rdw_post_rd1 got=%h exp=2", rd1); end
    n_cmp++; if (rd2 !== 32'h2) begin n_err++; $display("FAIL rdw_post_rd2 got=%h exp=2", rd2); end
    $display("read-during-write x9 done");
  endtask

  task automatic test_back_to_back();
    for (int i = 10; i < 14; i++) write_reg(5'(i), 32'hB000_0000 + 32'(i));
    for (int i = 10; i < 14; i++) begin
      rs1 = 5'(i); rs2 = 5'(23 - i); dbg_addr = 5'(i);
      #1;
      n_cmp++; if (rd1 !== 32'hB000_0000 + 32'(i)) begin n_err++; $display("FAIL b2b_rd1 x%0d got=%h", i, rd1); end
      n_cmp++; if (rd2 !== 32'hB000_0000 + 32'(23 - i)) begin n_err++; $display("FAIL b2b_rd2 x%0d got=%h", 23 - i, rd2); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] pre;
    pre = BYP ? 32'h99 : 32'h4;
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    @(negedge clk);
    RegWrite = 1'b1; rd = 5'd4; wd = 32'h99;
    rs1 = 5'd4; rs2 = 5'd31; dbg_addr = 5'd17;
    #1;
    n_cmp++; if (rd1 !== pre) begin n_err++; $display("FAIL arst_pre_rd1 got=%h exp=%h", rd1, pre); end
    n_cmp++; if (rd2 !== 32'd31) begin n_err++; $display("FAIL arst_pre_rd2 got=%h exp=1f", rd2); end
    n_cmp++; if (dbg_data !== 32'd17) begin n_err++; $display("FAIL arst_pre_dbg got=%h exp=11", dbg_data); end
    #2.5 rst_n = 1'b0;
    #1;
    n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL arst_now_rd1 got=%h exp=0", rd1); end
    n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL arst_now_rd2 got=%h exp=0", rd2); end
    n_cmp++; if (dbg_data !== 32'h0) begin n_err++; $display("FAIL arst_now_dbg got=%h exp=0", dbg_data); end
    #1 rst_n = 1'b1;
    RegWrite = 1'b0;
    #1;
    n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL arst_discard_x4 got=%h exp=0", rd1); end
    n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL arst_after_x31 got=%h exp=0", rd2); end
    write_reg(5'd4, 32'h44);
    n_cmp++; if (rd1 !== 32'h44) begin n_err++; $display("FAIL arst_recover_x4 got=%h exp=44", rd1); end
    $display("async reset pulse done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_write_enable();
    test_read_during_write();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
